// File: rtl/ipsl_ddrphy_pkg.sv
// Shared types and elaboration helpers for the DDR PHY DLL update logic.
package ipsl_ddrphy_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DLL_UP = 2'd1,
      WAIT   = 2'd2,
      ACK    = 2'd3
   } dll_state_t;

   function automatic int cnt_width(input int upd, input int wt);
      return $clog2((upd > wt) ? upd : wt) + 1;
   endfunction

   function automatic bit params_ok(input int nreq, input int upd,
                                    input int wt, input int gid_w);
      return (nreq >= 2) && (nreq <= 8) &&
             (upd >= 1) && (upd <= 16) &&
             (wt >= 1) && (wt <= 16) &&
             (gid_w >= $clog2(nreq));
   endfunction

endpackage

// File: rtl/ipsl_ddrphy_rr_arb.sv
// Round-robin next-grant selector with a registered priority pointer.
module ipsl_ddrphy_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int GID_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               take,
   output logic               any,
   output logic [GID_W-1:0]   gnt
);

   localparam logic [GID_W:0]   NR   = (GID_W+1)'(NUM_REQ);
   localparam logic [GID_W-1:0] LAST = GID_W'(NUM_REQ - 1);

   logic [GID_W-1:0] ptr;

   // Rotate so bit 0 is the pointer position, then take the lowest set bit.
   always_comb begin
      logic [2*NUM_REQ-1:0] rot;
      logic [GID_W:0]       idx;
      rot = {req, req} >> ptr;
      idx = '0;
      any = 1'b0;
      gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any && rot[i]) begin
            any = 1'b1;
            idx = {1'b0, ptr} + (GID_W+1)'(i);
            if (idx >= NR) idx = idx - NR;
            gnt = idx[GID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (take) begin
         ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
      end
   end

endmodule

// File: rtl/ipsl_ddrphy_dll_update_arb.sv
// DLL update controller: arbitrates requesters, pulses dll_update_n,
// waits for settle, then completes a four-phase ack with the winner.
module ipsl_ddrphy_dll_update_arb
   import ipsl_ddrphy_pkg::*;
#(
   parameter int                 NUM_REQ     = 4,
   parameter logic [NUM_REQ-1:0] ASYNC_MASK  = NUM_REQ'(1),
   parameter int                 UPD_CYCLES  = 2,
   parameter int                 WAIT_CYCLES = 2,
   parameter int                 GID_W       = 2
) (
   input  logic               rclk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] ack,
   input  logic               dll_hold,
   output logic               dll_update_n,
   output logic               busy,
   output logic [GID_W-1:0]   grant_id
);

   localparam int CNT_W = cnt_width(UPD_CYCLES, WAIT_CYCLES);
   localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(UPD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

   if (!params_ok(NUM_REQ, UPD_CYCLES, WAIT_CYCLES, GID_W)) begin : g_bad
      $error("ipsl_ddrphy_dll_update_arb: parameter out of range");
   end

   logic [NUM_REQ-1:0] req_s;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
      if (ASYNC_MASK[i]) begin : g_async
         logic [1:0] ff;
         always_ff @(posedge rclk) begin
            if (rst) ff <= '0;
            else     ff <= {ff[0], req[i]};
         end
         assign req_s[i] = ff[1];
      end else begin : g_direct
         assign req_s[i] = req[i];
      end
   end

   dll_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               take;
   logic               arb_any;
   logic [GID_W-1:0]   arb_gnt;
   logic [NUM_REQ-1:0] gmask;
   logic [NUM_REQ-1:0] ack_n;

   ipsl_ddrphy_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .GID_W   (GID_W)
   ) u_arb (
      .clk  (rclk),
      .rst  (rst),
      .req  (req_s),
      .take (take),
      .any  (arb_any),
      .gnt  (arb_gnt)
   );

   assign gmask = NUM_REQ'(1) << grant_id;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      take    = 1'b0;
      unique case (state)
         IDLE: begin
            if (arb_any && !dll_hold) begin
               state_n = DLL_UP;
               cnt_n   = '0;
               take    = 1'b1;
            end
         end
         DLL_UP: begin
            if (cnt == UPD_LAST) begin
               state_n = WAIT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT: begin
            if (cnt == WAIT_LAST) begin
               state_n = ACK;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         ACK: begin
            if ((req_s & gmask) == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The winner's ack follows its own request so a withdrawn request sees none.
   assign ack_n = (state == ACK) ? (req_s & gmask) : '0;

   always_ff @(posedge rclk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         grant_id     <= '0;
         ack          <= '0;
         dll_update_n <= 1'b1;
         busy         <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         ack          <= ack_n;
         dll_update_n <= (state != DLL_UP);
         busy         <= (state_n != IDLE);
         if (take) grant_id <= arb_gnt;
      end
   end

endmodule

// File: tb/tb_ipsl_ddrphy_dll_update_arb.sv
// Directed bench for the DLL update arbiter: vector tables plus corner sequences.
module tb_ipsl_ddrphy_dll_update_arb;

   logic       rclk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] ack;
   logic       dll_hold = 1'b0;
   logic       dll_update_n;
   logic       busy;
   logic [1:0] grant_id;

   int n_tests = 0;
   int n_fail = 0;
   int onehot_viol = 0;

   typedef struct {
      logic       rst;
      logic       hold;
      logic [3:0] req;
      logic [3:0] ack;
      logic       upd_n;
      logic       busy;
      logic [1:0] gid;
   } vec_t;

   vec_t vecs[$];

   ipsl_ddrphy_dll_update_arb #(
      .NUM_REQ     (4),
      .ASYNC_MASK  (4'b0001),
      .UPD_CYCLES  (2),
      .WAIT_CYCLES (2),
      .GID_W       (2)
   ) dut (
      .rclk         (rclk),
      .rst          (rst),
      .req          (req),
      .ack          (ack),
      .dll_hold     (dll_hold),
      .dll_update_n (dll_update_n),
      .busy         (busy),
      .grant_id     (grant_id)
   );

   always #5 rclk = ~rclk;

   always @(negedge rclk) begin
      if (!rst && !$onehot0(ack)) onehot_viol++;
   end

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic h,
                               input logic [3:0] rq, input logic [3:0] a,
                               input logic u, input logic b,
                               input logic [1:0] g);
      vec_t v;
      v.rst = r; v.hold = h; v.req = rq;
      v.ack = a; v.upd_n = u; v.busy = b; v.gid = g;
      vecs.push_back(v);
   endfunction

   task automatic run_vecs(input int first, input int last);
      for (int i = first; i < last; i++) begin
         rst = vecs[i].rst;
         dll_hold = vecs[i].hold;
         req = vecs[i].req;
         tick();
         check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
         check($sformatf("v%0d_upd_n", i), 32'(dll_update_n),
               32'(vecs[i].upd_n));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("v%0d_gid", i), 32'(grant_id), 32'(vecs[i].gid));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      dll_hold = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int s1_a, s1_b, s2_b;
   int order[5] = '{0, 1, 2, 3, 0};

   initial begin
      // reset
      add(1, 0, 4'b0000, 4'b0000, 1, 0, 2'd0);
      // sync req[1]: strobe after edges 2,3; ack after 6..8; drop -> idle at 9
      s1_a = vecs.size();
      add(0, 0, 4'b0010, 4'b0000, 1, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0000, 0, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0000, 0, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0000, 1, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0000, 1, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0010, 1, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0010, 1, 1, 2'd1);
      add(0, 0, 4'b0010, 4'b0010, 1, 1, 2'd1);
      add(0, 0, 4'b0000, 4'b0000, 1, 0, 2'd1);
      add(0, 0, 4'b0000, 4'b0000, 1, 0, 2'd1);
      s1_b = vecs.size();
      // async req[0]: everything two cycles later
      add(0, 0, 4'b0001, 4'b0000, 1, 0, 2'd1);
      add(0, 0, 4'b0001, 4'b0000, 1, 0, 2'd1);
      add(0, 0, 4'b0001, 4'b0000, 1, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0000, 0, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0000, 0, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0000, 1, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0000, 1, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0001, 1, 1, 2'd0);
      add(0, 0, 4'b0001, 4'b0001, 1, 1, 2'd0);
      add(0, 0, 4'b0000, 4'b0001, 1, 1, 2'd0);
      add(0, 0, 4'b0000, 4'b0001, 1, 1, 2'd0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0, 2'd0);
      add(0, 0, 4'b0000, 4'b0000, 1, 0, 2'd0);
      s2_b = vecs.size();

      tick();
      run_vecs(0, s2_b);

      // round robin with all four requesting
      do_reset();
      dll_hold = 1'b1;
      req = 4'b1111;
      repeat (3) tick();
      dll_hold = 1'b0;
      for (int n = 0; n < 5; n++) begin
         logic got;
         logic [3:0] exp_ack;
         got = 1'b0;
         exp_ack = 4'b0001 << order[n];
         for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (ack != '0) got = 1'b1;
         end
         check($sformatf("rr%0d_seen", n), 32'(got), 32'd1);
         check($sformatf("rr%0d_ack", n), 32'(ack), 32'(exp_ack));
         check($sformatf("rr%0d_gid", n), 32'(grant_id), 32'(order[n]));
         req[order[n]] = 1'b0;
         for (int c = 0; c < 10 && ack != '0; c++) tick();
         check($sformatf("rr%0d_ack_drop", n), 32'(ack), 32'd0);
         req[order[n]] = 1'b1;
      end
      check("rr_onehot", 32'(onehot_viol), 32'd0);

      // hold defers a start but never shortens a running strobe
      do_reset();
      dll_hold = 1'b1;
      req = 4'b0100;
      for (int c = 0; c < 20; c++) begin
         tick();
         check($sformatf("hold%0d_upd_n", c), 32'(dll_update_n), 32'd1);
         check($sformatf("hold%0d_busy", c), 32'(busy), 32'd0);
      end
      dll_hold = 1'b0;
      tick();
      check("hold_rel_busy", 32'(busy), 32'd1);
      check("hold_rel_upd_n", 32'(dll_update_n), 32'd1);
      dll_hold = 1'b1;
      tick();
      check("hold_up0", 32'(dll_update_n), 32'd0);
      tick();
      check("hold_up1", 32'(dll_update_n), 32'd0);
      tick();
      check("hold_up_end", 32'(dll_update_n), 32'd1);
      for (int c = 0; c < 20 && ack != 4'b0100; c++) tick();
      check("hold_ack", 32'(ack), 32'h4);
      req = '0;
      tick();
      check("hold_ack_drop", 32'(ack), 32'd0);
      check("hold_idle", 32'(busy), 32'd0);
      dll_hold = 1'b0;

      // req[3] withdrawn during WAIT
      do_reset();
      req = 4'b1000;
      repeat (3) tick();
      check("abort_upd_n", 32'(dll_update_n), 32'd0);
      check("abort_gid", 32'(grant_id), 32'd3);
      req = '0;
      tick();
      check("abort_wait_ack", 32'(ack), 32'd0);
      tick();
      check("abort_ack_state", 32'(busy), 32'd1);
      check("abort_ack_none", 32'(ack), 32'd0);
      tick();
      check("abort_idle", 32'(busy), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("abort%0d_ack", c), 32'(ack), 32'd0);
      end

      // reset during DLL_UP, then a fresh request
      do_reset();
      req = 4'b0010;
      tick();
      tick();
      check("rmid_up", 32'(dll_update_n), 32'd0);
      rst = 1'b1;
      req = '0;
      tick();
      check("rmid_upd_n", 32'(dll_update_n), 32'd1);
      check("rmid_ack", 32'(ack), 32'd0);
      check("rmid_busy", 32'(busy), 32'd0);
      check("rmid_gid", 32'(grant_id), 32'd0);
      run_vecs(s1_a, s1_b);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ipsl_ddrphy_dll_update_arb.md
Name: ipsl_ddrphy_dll_update_arb

Overview:
- Parametrised N-requester DLL update controller for the DDR PHY.
- Arbitrates update requests round-robin from the reset controller, training, and periodic/host sources; some are asynchronous, some synchronous.
- Drives the active-low dll_update_n strobe for a programmable width, waits a programmable settle time, then completes a four-phase handshake with the granted requester.
- Adds a hold input that defers new updates, e.g. while read data capture is in progress.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ASYNC_MASK, 4'b0001, bit i=1: req[i] passes through a 2-flop synchroniser; bit i=0: used directly.
- UPD_CYCLES, 2, cycles dll_update_n is held low (1..16).
- WAIT_CYCLES, 2, settle cycles after dll_update_n returns high, before ack (1..16).
- GID_W, 2, width of grant_id; must be >= clog2(NUM_REQ).

Ports:
- rclk  in  1  PHY reference clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  update request per source; level, held until ack.
- ack  out  NUM_REQ  per-source acknowledge; one-hot or zero.
- dll_hold  in  1  1 = do not start a new update; an update in progress is unaffected.
- dll_update_n  out  1  active-low DLL update strobe to the DLL primitive.
- busy  out  1  1 whenever state != IDLE.
- grant_id  out  GID_W  index of the source currently or last granted.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, ack=0, dll_update_n=1, busy=0, grant_id=0, RR pointer=0, synchronisers cleared, counter=0.
- Reset mid-operation aborts immediately; no ack is issued. dll_update_n returns to 1 on the following edge.
- req_s[i] is the 2-flop synchronised req[i] if ASYNC_MASK[i]=1, else the raw req[i].
- All outputs are registered and derived from the current state.
- IDLE:
  - If any req_s is set and dll_hold=0, grant the first set bit at or after the RR pointer, scanning upward with wrap.
  - Latch grant_id, set the RR pointer to grant_id+1 (mod NUM_REQ), go to DLL_UP, clear the counter.
  - If dll_hold=1, stay in IDLE.
- DLL_UP: stay UPD_CYCLES cycles, then go to WAIT with the counter cleared.
- WAIT: stay WAIT_CYCLES cycles, then go to ACK.
- ACK: when req_s[grant_id]=0, go to IDLE. Other requests are ignored until IDLE.
- dll_update_n <= 0 iff state==DLL_UP, else 1.
  - Consequence: low for exactly UPD_CYCLES consecutive cycles, starting one cycle after entry to DLL_UP.
- ack[grant_id] <= (state==ACK) && req_s[grant_id]; all other ack bits are 0.
  - A requester that drops req before ACK (abort) gets no ack. The update still completes, and ACK exits on the next cycle.
- Latency, synchronous source, req rising at edge T0 in IDLE:
  - DLL_UP at T1..T_UPD.
  - dll_update_n low at T2..T(UPD+1).
  - WAIT for WAIT_CYCLES cycles.
  - ACK state at T(1+UPD+WAIT); ack high at T(2+UPD+WAIT).
  - Asynchronous sources add 2 cycles.
- After the granted req drops: ack falls 1 cycle later (plus sync delay for async sources). The earliest next grant is from IDLE on the following cycle.
- Counter width is clog2(max(UPD_CYCLES, WAIT_CYCLES))+1. Terminal comparison is against PARAM-1; no wrap is reachable.
- Simultaneous requests: strict round-robin; each source is served within NUM_REQ grants.
- Illegal state encodings go to IDLE.

Decomposition:
- Shared package ipsl_ddrphy_pkg holds:
  - state enum IDLE/DLL_UP/WAIT/ACK (2 bits).
  - localparam function for the counter width.
  - parameter range checks (elaboration-time assertions).
- One sub-module: ipsl_ddrphy_rr_arb (combinational next-grant from the req vector and pointer, plus registered pointer update), reusable elsewhere in the PHY.
- Synchroniser is a generate loop, not a separate module.

Test Plan:
- Single sync req[1], UPD=2, WAIT=2, req at cycle 0 -> dll_update_n=0 at cycles 2,3 only; ack[1]=1 from cycle 6; drop req at 8 -> ack[1]=0 at 9; busy=0 at 9.
- Async req[0] (ASYNC_MASK bit 0) -> every event delayed 2 cycles vs previous case; ack[0] at cycle 8.
- req=4'b1111 held, each source drops req 1 cycle after its ack -> grant order 0,1,2,3,0; exactly one ack bit high at any time.
- dll_hold=1 with req[2] set for 20 cycles -> dll_update_n stays 1, busy=0; hold released -> dll_update_n low 2 cycles later. Hold raised during DLL_UP does not shorten the strobe.
- req[3] dropped during WAIT -> ack[3] never asserts; state returns to IDLE one cycle after ACK entry.
- rst=1 during DLL_UP -> dll_update_n=1, ack=0, busy=0 on the next edge; a fresh request after reset behaves like the first scenario.
